// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared constants for the BlackParrot FPGA host buffers: status-word layout,
// empty-read sentinel and CSR channel indices.
package blackparrot_fpga_host_pkg;

    localparam int FULL_BIT       = 31;
    localparam int EMPTY_READ_BIT = 30;
    localparam int COUNT_LSB      = 0;
    localparam int COUNT_W        = 16;

    localparam logic [31:0] EMPTY_READ_SENTINEL = 32'hFFFF_FFFF;

    localparam int CH_DATA   = 0;
    localparam int CH_STATUS = 1;

    // Field order mirrors FULL_BIT / EMPTY_READ_BIT / COUNT_LSB above.
    typedef struct packed {
        logic               full;
        logic               empty_read;
        logic [13:0]        rsvd;
        logic [COUNT_W-1:0] count;
    } status_word_t;

endpackage

// File: rtl/blackparrot_fpga_host_read_buffer_mem.sv
// 1R1W register file backing the host read buffer: synchronous write,
// asynchronous read so the head word is visible the cycle after it is written.
module blackparrot_fpga_host_read_buffer_mem
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int ELS_P   = 16,
    localparam int ADDR_W = $clog2(ELS_P)
) (
    input  logic               clk,
    input  logic               w_v,
    input  logic [ADDR_W-1:0]  w_addr,
    input  logic [WIDTH_P-1:0] w_data,
    input  logic [ADDR_W-1:0]  r_addr,
    output logic [WIDTH_P-1:0] r_data
);

    logic [WIDTH_P-1:0] mem [ELS_P];

    always_ff @(posedge clk) begin
        if (w_v) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/blackparrot_fpga_host_read_buffer.sv
// Host-side word buffer exposed as two CSR FIFO channels (data pop, status peek).
// Optional BP_FPGA_HOST_READ_BUFFER_EMPTY_READ_EN makes empty data reads return a sentinel.
module blackparrot_fpga_host_read_buffer
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int S_AXIL_DATA_WIDTH = 32,
    parameter int IN_WIDTH_P        = 8,
    parameter int ELS_P             = 16
) (
    input  logic                                s_axil_aclk,
    input  logic                                s_axil_aresetn,
    input  logic                                v_i,
    input  logic [IN_WIDTH_P-1:0]               data_i,
    output logic                                ready_and_o,
    output logic [1:0]                          fifo_v_o,
    output logic [1:0][S_AXIL_DATA_WIDTH-1:0]   fifo_data_o,
    input  logic [1:0]                          fifo_yumi_i
);

    localparam int PTR_W = $clog2(ELS_P);
    localparam int CNT_W = PTR_W + 1;

    // active_reg holds every output at zero through reset and releases them the
    // cycle after reset deasserts, keeping outputs purely registered-state driven.
    logic                  active_reg;
    logic [PTR_W-1:0]      wptr_reg;
    logic [PTR_W-1:0]      rptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic                  empty_read_reg;
    logic                  empty_read_next;
    logic                  enq;
    logic                  deq;
    logic                  empty;
    logic                  full;
    logic [IN_WIDTH_P-1:0] head_word;
    logic [S_AXIL_DATA_WIDTH-1:0] data_word;
    logic [S_AXIL_DATA_WIDTH-1:0] status_word;
    status_word_t          status_fields;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CNT_W'(ELS_P));
    assign ready_and_o = active_reg & ~full;

    assign fifo_v_o[CH_STATUS] = active_reg;
`ifdef BP_FPGA_HOST_READ_BUFFER_EMPTY_READ_EN
    assign fifo_v_o[CH_DATA]   = active_reg;
`else
    assign fifo_v_o[CH_DATA]   = active_reg & ~empty;
`endif

    assign enq = v_i & ready_and_o;
    assign deq = fifo_yumi_i[CH_DATA] & fifo_v_o[CH_DATA] & ~empty;

    always_comb begin
        count_next = count_reg;
        if (enq && !deq) begin
            count_next = count_reg + CNT_W'(1);
        end else if (deq && !enq) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

`ifdef BP_FPGA_HOST_READ_BUFFER_EMPTY_READ_EN
    logic empty_read_set;
    assign empty_read_set = fifo_yumi_i[CH_DATA] & fifo_v_o[CH_DATA] & empty;

    // A status read clears the flag, but a same-cycle empty read must not be lost.
    always_comb begin
        empty_read_next = empty_read_reg;
        if (fifo_yumi_i[CH_STATUS]) begin
            empty_read_next = 1'b0;
        end
        if (empty_read_set) begin
            empty_read_next = 1'b1;
        end
    end
`else
    logic yumi_status_unused;
    assign yumi_status_unused = fifo_yumi_i[CH_STATUS];
    assign empty_read_next    = 1'b0;
`endif

    always_ff @(posedge s_axil_aclk) begin
        if (!s_axil_aresetn) begin
            active_reg     <= 1'b0;
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            empty_read_reg <= 1'b0;
        end else begin
            active_reg     <= 1'b1;
            count_reg      <= count_next;
            empty_read_reg <= empty_read_next;
            if (enq) begin
                wptr_reg <= wptr_reg + PTR_W'(1);
            end
            if (deq) begin
                rptr_reg <= rptr_reg + PTR_W'(1);
            end
        end
    end

    blackparrot_fpga_host_read_buffer_mem #(
        .WIDTH_P (IN_WIDTH_P),
        .ELS_P   (ELS_P)
    ) mem_inst (
        .clk    (s_axil_aclk),
        .w_v    (enq & s_axil_aresetn),
        .w_addr (wptr_reg),
        .w_data (data_i),
        .r_addr (rptr_reg),
        .r_data (head_word)
    );

    always_comb begin
        status_fields            = '0;
        status_fields.full       = full;
        status_fields.empty_read = empty_read_reg;
        status_fields.count      = COUNT_W'(count_reg);

        status_word       = '0;
        status_word[31:0] = status_fields;

        data_word                   = '0;
        data_word[IN_WIDTH_P-1:0]   = head_word;
`ifdef BP_FPGA_HOST_READ_BUFFER_EMPTY_READ_EN
        if (empty) begin
            data_word[31:0] = EMPTY_READ_SENTINEL;
        end
`endif

        fifo_data_o = '0;
        if (active_reg) begin
            fifo_data_o[CH_DATA]   = data_word;
            fifo_data_o[CH_STATUS] = status_word;
        end
    end

endmodule

// File: tb/tb_blackparrot_fpga_host_read_buffer.sv
// Self-checking bench for blackparrot_fpga_host_read_buffer: vector table,
// directed corner sequences and random traffic against a queue reference model.
module tb_blackparrot_fpga_host_read_buffer;

`ifdef BP_FPGA_HOST_READ_BUFFER_EMPTY_READ_EN
    localparam bit EMPTY_READ_EN = 1'b1;
`else
    localparam bit EMPTY_READ_EN = 1'b0;
`endif
    localparam int ELS = 16;

    logic             clk;
    logic             s_axil_aresetn;
    logic             v_i;
    logic [7:0]       data_i;
    logic             ready_and_o;
    logic [1:0]       fifo_v_o;
    logic [1:0][31:0] fifo_data_o;
    logic [1:0]       fifo_yumi_i;

    blackparrot_fpga_host_read_buffer #(
        .S_AXIL_DATA_WIDTH (32),
        .IN_WIDTH_P        (8),
        .ELS_P             (ELS)
    ) dut (
        .s_axil_aclk    (clk),
        .s_axil_aresetn (s_axil_aresetn),
        .v_i            (v_i),
        .data_i         (data_i),
        .ready_and_o    (ready_and_o),
        .fifo_v_o       (fifo_v_o),
        .fifo_data_o    (fifo_data_o),
        .fifo_yumi_i    (fifo_yumi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffered words in arrival order plus out-of-reset and sticky flags.
    logic [7:0] q[$];
    bit         active_m = 1'b0;
    bit         sticky_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_st;
        exp_st = 32'h0;
        if (active_m) begin
            exp_st = {(q.size() == ELS), sticky_m, 14'd0, 16'(q.size())};
        end
        chk("ready", {31'd0, ready_and_o}, {31'd0, active_m && (q.size() < ELS)});
        chk("fifo_v", {30'd0, fifo_v_o},
            {30'd0, active_m, active_m && (EMPTY_READ_EN || q.size() != 0)});
        chk("status", fifo_data_o[1], exp_st);
        if (!active_m) begin
            chk("data_rst", fifo_data_o[0], 32'h0);
        end else if (q.size() != 0) begin
            chk("data", fifo_data_o[0], {24'd0, q[0]});
        end else if (EMPTY_READ_EN) begin
            chk("data_sentinel", fifo_data_o[0], 32'hFFFF_FFFF);
        end
    endtask

    // One clock: check current outputs against the model, apply inputs, advance both.
    task automatic cycle(input bit v, input logic [7:0] d, input bit y0, input bit y1);
        bit acc;
        bit dq;
        bit er;
        check_outputs();
        v_i         = v;
        data_i      = d;
        fifo_yumi_i = {y1, y0};
        acc = s_axil_aresetn && active_m && v && (q.size() < ELS);
        dq  = s_axil_aresetn && active_m && y0 && (q.size() > 0);
        er  = EMPTY_READ_EN && s_axil_aresetn && active_m && y0 && (q.size() == 0);
        @(posedge clk);
        if (!s_axil_aresetn) begin
            q.delete();
            active_m = 1'b0;
            sticky_m = 1'b0;
            $display("reset cycle");
        end else begin
            if (dq) begin
                $display("deq %02h", q[0]);
                void'(q.pop_front());
            end
            if (acc) begin
                $display("enq %02h", d);
                q.push_back(d);
            end
            if (y1) sticky_m = 1'b0;
            if (er) begin
                sticky_m = 1'b1;
                $display("empty read");
            end
            active_m = 1'b1;
        end
        #1;
        v_i         = 1'b0;
        fifo_yumi_i = 2'b00;
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          y0;
        bit          y1;
        bit          exp_ready;
        logic [1:0]  exp_v;
        logic [31:0] exp_st;
        bit          chk_d;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [1:0] ev_empty;
        int         sent;
        bit         done;
        ev_empty = EMPTY_READ_EN ? 2'b11 : 2'b10;

        vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 2'b11, 32'h1, 1'b1, 32'h11};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 2'b11, 32'h2, 1'b1, 32'h11};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'b11, 32'h1, 1'b1, 32'h22};
        vecs[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 2'b11, 32'h1, 1'b1, 32'h33};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, ev_empty, 32'h0, EMPTY_READ_EN, 32'hFFFF_FFFF};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, ev_empty, 32'h0, EMPTY_READ_EN, 32'hFFFF_FFFF};
        vecs[6] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 2'b11, 32'h1, 1'b1, 32'hA5};
        vecs[7] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 2'b11, 32'h2, 1'b1, 32'hA5};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'b11, 32'h1, 1'b1, 32'h5A};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, ev_empty, 32'h0, EMPTY_READ_EN, 32'hFFFF_FFFF};

        // Initial reset: DUT state is unknown until the first sampled reset edge.
        s_axil_aresetn = 1'b0;
        v_i            = 1'b0;
        data_i         = 8'h00;
        fifo_yumi_i    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready_and_o}, 32'h0);
        chk("rst_fifo_v", {30'd0, fifo_v_o}, 32'h0);
        chk("rst_data0", fifo_data_o[0], 32'h0);
        chk("rst_data1", fifo_data_o[1], 32'h0);
        s_axil_aresetn = 1'b1;
        @(posedge clk);
        #1;
        active_m = 1'b1;
        chk("post_rst_ready", {31'd0, ready_and_o}, 32'h1);
        chk("post_rst_fifo_v", {30'd0, fifo_v_o}, {30'd0, ev_empty});
        check_outputs();

        // Vector table
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].y0, vecs[i].y1);
            chk($sformatf("vec%0d_ready", i), {31'd0, ready_and_o}, {31'd0, vecs[i].exp_ready});
            chk($sformatf("vec%0d_v", i), {30'd0, fifo_v_o}, {30'd0, vecs[i].exp_v});
            chk($sformatf("vec%0d_status", i), fifo_data_o[1], vecs[i].exp_st);
            if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), fifo_data_o[0], vecs[i].exp_d);
        end

        // Fill to full, offer a 17th byte, then drain in order
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
        chk("full_status", fifo_data_o[1], 32'h8000_0010);
        chk("full_ready", {31'd0, ready_and_o}, 32'h0);
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        chk("full_hold_status", fifo_data_o[1], 32'h8000_0010);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), fifo_data_o[0], 32'(8'h41 + i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drained_v0", {31'd0, fifo_v_o[0]}, {31'd0, EMPTY_READ_EN});
        chk("drained_status", fifo_data_o[1], 32'h0);

        // Simultaneous enqueue/dequeue at full, then steady state at count 5
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        chk("simul_full_status", fifo_data_o[1], 32'h0000_000F);
        chk("simul_full_ready", {31'd0, ready_and_o}, 32'h1);
        chk("simul_full_head", fifo_data_o[0], 32'h61);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("count5", fifo_data_o[1], 32'h5);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            chk($sformatf("steady5_%0d", i), {16'd0, fifo_data_o[1][15:0]}, 32'h5);
        end
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Pointer wrap: 40 bytes with random gaps on both sides
        sent = 0;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            bit v;
            bit y0;
            v  = (sent < 40) && ($urandom_range(0, 3) != 0);
            y0 = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            if (v && q.size() < ELS) sent++;
            cycle(v, 8'($urandom_range(0, 255)), y0, 1'b0);
            done = (sent == 40) && (q.size() == 0);
        end
        chk("wrap_done", {31'd0, done}, 32'h1);

        // Empty read behaviour
`ifdef BP_FPGA_HOST_READ_BUFFER_EMPTY_READ_EN
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("er_data", fifo_data_o[0], 32'hFFFF_FFFF);
        chk("er_status", fifo_data_o[1], 32'h4000_0000);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("er_clear", fifo_data_o[1], 32'h0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("er_set_wins", fifo_data_o[1], 32'h4000_0000);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
`else
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            chk($sformatf("empty_stall%0d", i), {31'd0, fifo_v_o[0]}, 32'h0);
        end
`endif

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            bit y0;
            y0 = (q.size() > 0 || EMPTY_READ_EN) && ($urandom_range(0, 2) != 0);
            cycle($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)), y0,
                  $urandom_range(0, 7) == 0);
        end
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Mid-stream reset with 7 words buffered; the word offered in reset is dropped
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        chk("pre_rst_status", fifo_data_o[1], 32'h7);
        s_axil_aresetn = 1'b0;
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("mid_rst_ready", {31'd0, ready_and_o}, 32'h0);
        chk("mid_rst_fifo_v", {30'd0, fifo_v_o}, 32'h0);
        chk("mid_rst_data0", fifo_data_o[0], 32'h0);
        chk("mid_rst_data1", fifo_data_o[1], 32'h0);
        s_axil_aresetn = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("after_rst_status", fifo_data_o[1], 32'h0);
        chk("after_rst_fifo_v", {30'd0, fifo_v_o}, {30'd0, ev_empty});
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("after_rst_first", fifo_data_o[0], 32'h3C);
        chk("after_rst_count", fifo_data_o[1], 32'h1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
